pkt_stream_sender: RTL

//  Single-clock, parametrised successor to the packet output buffer: stores fixed-length packets of WORD_W-bit

---
 rtl/pkt_send_pkg.sv | 7 +
 rtl/pkt_ovf_stretch.sv | 32 +++
 rtl/pkt_stream_sender.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pkt_send_pkg.sv
// pkt_send_pkg: shared states and sync-frame constants for the packet stream sender
package pkt_send_pkg;
  typedef enum logic [1:0] {IDLE, DATA, SYNC} state_e;
  localparam logic [7:0] SYNC_BYTE_FF  = 8'hFF;
  localparam logic [7:0] SYNC_BYTE_END = 8'h7F;
  localparam int         SYNC_LEN      = 4;
endpackage

// File: rtl/pkt_ovf_stretch.sv
// pkt_ovf_stretch: sticky overflow latch plus a stretch counter that keeps the LED visible after the latch clears
module pkt_ovf_stretch #(
  parameter int STRETCH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic ovf,
  output logic led
);
  localparam int CW = STRETCH > 1 ? $clog2(STRETCH) : 1;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // clear beats set; the counter reloads while latched and bleeds down afterwards
  always_comb begin
    ovf_d = clr ? 1'b0 : (set | ovf_q);
    cnt_d = ovf_q ? CW'(STRETCH - 1) : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  end
  // latch and stretch state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end
  assign ovf = ovf_q;
  assign led = ovf_q | (cnt_q != '0);
endmodule

// File: rtl/pkt_stream_sender.sv
// pkt_stream_sender: buffers fixed-length packets, streams committed ones LSB-byte-first with FF FF FF 7F keepalives; PKTSEND_HIWATER_EN adds the hiwater port
module pkt_stream_sender
  import pkt_send_pkg::*;
#(
  parameter int WORD_W        = 16,
  parameter int DEPTH_LOG2    = 12,
  parameter int PKT_LOG2      = 3,
  parameter int SYNC_INTERVAL = 2**21,
  parameter int OVF_STRETCH   = 2**26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync_ok,
  input  logic                  wd_valid,
  input  logic [WORD_W-1:0]     wd_data,
  input  logic                  pkt_reset,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ovf_led
`ifdef PKTSEND_HIWATER_EN
  , output logic [DEPTH_LOG2-1:0] hiwater
`endif
);
  localparam int BYTES = WORD_W / 8;
  localparam int BW    = BYTES > 1 ? $clog2(BYTES) : 1;
  localparam int SW    = SYNC_INTERVAL > 1 ? $clog2(SYNC_INTERVAL) : 1;
  logic [WORD_W-1:0]     mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d, cwp_q, cwp_d, rp_q, rp_d;
  logic [BW-1:0]         b_q, b_d;
  logic [1:0]            si_q, si_d;
  logic [SW-1:0]         sc_q, sc_d;
  state_e                state_q, state_d;
  logic [7:0]            out_data_q, out_data_d, cur_byte;
  logic                  out_valid_q, out_valid_d;
  logic                  ovf, full, we, drop, load, bnd, avail, last_b, sync_end, go_sync, go_data;
  assign full     = DEPTH_LOG2'(wp_q + 1'b1) == rp_q;
  assign we       = wd_valid & ~pkt_reset & ~full & ~ovf;
  assign drop     = wd_valid & ~pkt_reset & (full | ovf);
  assign avail    = cwp_q != rp_q;
  assign load     = ~out_valid_q | out_ready;
  assign bnd      = rp_q[PKT_LOG2-1:0] == '0 && b_q == '0;
  assign last_b   = b_q == BW'(BYTES - 1);
  assign sync_end = si_q == 2'(SYNC_LEN - 1);
  assign cur_byte = 8'(mem[rp_q] >> {b_q, 3'b000});
  assign go_sync  = state_q == SYNC || (state_q == IDLE && bnd && sc_q == '0 && sync_ok);
  assign go_data  = !go_sync && (state_q == DATA || (state_q == IDLE && avail));
  pkt_ovf_stretch #(.STRETCH(OVF_STRETCH)) u_ovf (
    .clk (clk),
    .rst (rst),
    .set (drop),
    .clr (pkt_reset),
    .ovf (ovf),
    .led (ovf_led)
  );
  // packet RAM: accepted words land at the write pointer
  always_ff @(posedge clk) begin
    if (we) mem[wp_q] <= wd_data;
  end
  // write side: pkt_reset rewinds to the last commit, a completed packet commits on its final word
  always_comb begin
    wp_d  = pkt_reset ? cwp_q : (we ? DEPTH_LOG2'(wp_q + 1'b1) : wp_q);
    cwp_d = we && wp_d[PKT_LOG2-1:0] == '0 ? wp_d : cwp_q;
  end
  // read FSM and output register, advanced only when the output register is free to load
  always_comb begin
    state_d     = state_q;
    rp_d        = rp_q;
    b_d         = b_q;
    si_d        = si_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sc_d        = sc_q != '0 ? sc_q - 1'b1 : sc_q;
    if (load) begin
      out_valid_d = go_sync | go_data;
      if (go_sync) begin
        out_data_d = sync_end ? SYNC_BYTE_END : SYNC_BYTE_FF;
        si_d       = si_q + 1'b1;
        state_d    = sync_end ? IDLE : SYNC;
        sc_d       = sync_end ? SW'(SYNC_INTERVAL - 1) : sc_d;
      end else if (go_data) begin
        out_data_d = cur_byte;
        b_d        = last_b ? '0 : b_q + 1'b1;
        rp_d       = last_b ? DEPTH_LOG2'(rp_q + 1'b1) : rp_q;
        state_d    = last_b && rp_d[PKT_LOG2-1:0] == '0 ? IDLE : DATA;
      end
    end
  end
  // pointer, FSM and output state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q        <= '0;
      cwp_q       <= '0;
      rp_q        <= '0;
      b_q         <= '0;
      si_q        <= '0;
      sc_q        <= '0;
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wp_q        <= wp_d;
      cwp_q       <= cwp_d;
      rp_q        <= rp_d;
      b_q         <= b_d;
      si_q        <= si_d;
      sc_q        <= sc_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef PKTSEND_HIWATER_EN
  logic [DEPTH_LOG2-1:0] fill, hiwater_q, hiwater_d;
  assign fill      = cwp_q - rp_q;
  assign hiwater_d = fill > hiwater_q ? fill : hiwater_q;
  assign hiwater   = hiwater_q;
  // deepest committed backlog seen since reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hiwater_q <= '0;
    else      hiwater_q <= hiwater_d;
  end
`endif
endmodule
